// File: rtl/fft2d_pkg.sv
// Shared types and defaults for the 2-D FFT streaming port.
package fft2d_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_COMPUTE,
    ST_DRAIN,
    ST_FLUSH
  } fft_state_e;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_LOG2N      = 6;
  localparam int DEF_OUT_WIDTH  = 32;

  // Frame address is {row, col, im}: LOG2N + LOG2N + 1 bits.
  function automatic int addr_width(input int log2n);
    return 2 * log2n + 1;
  endfunction

endpackage

// File: rtl/fft2d_stream_port_if.sv
// Frame-memory and drain-monitor signals of the FFT streaming port.
// master = streaming port, slave = memory / monitor side.
interface fft2d_stream_port_if
  import fft2d_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int LOG2N      = DEF_LOG2N,
  parameter int OUT_WIDTH  = DEF_OUT_WIDTH
);
  localparam int AW = addr_width(LOG2N);

  logic                  o_mem_wr_en;
  logic                  o_mem_rd_en;
  logic [AW-1:0]         o_mem_addr;
  logic [DATA_WIDTH-1:0] o_mem_wr_data;
  logic [DATA_WIDTH-1:0] i_mem_rd_data;
  logic                  o_out_valid;
  logic [OUT_WIDTH-1:0]  o_out_data;
  logic [AW-1:0]         o_out_idx;

  modport master (
    output o_mem_wr_en, o_mem_rd_en, o_mem_addr, o_mem_wr_data,
    output o_out_valid, o_out_data, o_out_idx,
    input  i_mem_rd_data
  );

  modport slave (
    input  o_mem_wr_en, o_mem_rd_en, o_mem_addr, o_mem_wr_data,
    input  o_out_valid, o_out_data, o_out_idx,
    output i_mem_rd_data
  );

endinterface

// File: rtl/fft2d_bitrev.sv
// Combinational LOG2N-bit reverser for drain-order addressing.
// Only present when FFT2D_BITREV_EN is defined; the natural-order
// build carries no reverse logic at all.
`ifdef FFT2D_BITREV_EN
module fft2d_bitrev #(
  parameter int LOG2N = 6
) (
  input  logic [LOG2N-1:0] din,
  output logic [LOG2N-1:0] dout
);
  for (genvar b = 0; b < LOG2N; b++) begin : g_rev
    assign dout[b] = din[LOG2N-1-b];
  end
endmodule
`endif

// File: rtl/fft2d_stream_port.sv
// 2-D FFT frame streaming port: loads a frame from the shared bus into
// frame memory, kicks the core, then drains the result back on the bus.
// Optional FFT2D_BITREV_EN: drain reads in bit-reversed row/col order.
module fft2d_stream_port
  import fft2d_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int LOG2N      = DEF_LOG2N,
  parameter int OUT_WIDTH  = DEF_OUT_WIDTH
) (
  input  logic                  i_fft_base_clock,
  input  logic                  i_fft_reset,
  inout  wire  [DATA_WIDTH-1:0] io_fft_data,
  input  logic                  i_fft_start,
  output logic                  o_TIP,
  output logic                  o_busy,
  output logic                  o_core_go,
  input  logic                  i_core_done,
  fft2d_stream_port_if.master   mem
);

  localparam int AW = addr_width(LOG2N);
  // Last word index of a frame: 2*N*N - 1.
  localparam logic [AW-1:0] CNT_LAST = AW'(2 * (1 << (2 * LOG2N)) - 1);

  fft_state_e      state_q, state_d;
  logic [AW-1:0]   cnt_q;
  logic            cnt_last;
  logic            go_q;
  logic            drv_en_q;   // bus carries drained data this cycle
  logic [AW-1:0]   drv_idx_q;  // sequence index of the word on the bus
  logic [AW-1:0]   rd_addr;

  assign cnt_last = (cnt_q == CNT_LAST);

`ifdef FFT2D_BITREV_EN
  logic [LOG2N-1:0] row_rev, col_rev;

  fft2d_bitrev #(.LOG2N(LOG2N)) u_row_rev (
    .din  (cnt_q[AW-1 -: LOG2N]),
    .dout (row_rev)
  );

  fft2d_bitrev #(.LOG2N(LOG2N)) u_col_rev (
    .din  (cnt_q[LOG2N -: LOG2N]),
    .dout (col_rev)
  );

  assign rd_addr = {row_rev, col_rev, cnt_q[0]};
`else
  assign rd_addr = cnt_q;
`endif

  // State register; reset overrides every other input.
  always_ff @(posedge i_fft_base_clock) begin
    if (i_fft_reset) state_q <= ST_IDLE;
    else             state_q <= state_d;
  end

  // Next-state and state-decoded outputs.
  always_comb begin
    state_d           = state_q;
    o_busy            = 1'b0;
    o_TIP             = 1'b0;
    mem.o_mem_wr_en   = 1'b0;
    mem.o_mem_rd_en   = 1'b0;
    mem.o_mem_addr    = '0;
    mem.o_mem_wr_data = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (i_fft_start) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        o_busy            = 1'b1;
        o_TIP             = 1'b1;
        mem.o_mem_wr_en   = 1'b1;
        mem.o_mem_addr    = cnt_q;
        mem.o_mem_wr_data = io_fft_data;
        if (cnt_last) state_d = ST_COMPUTE;
      end
      ST_COMPUTE: begin
        o_busy = 1'b1;
        if (i_core_done) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        o_busy          = 1'b1;
        o_TIP           = 1'b1;
        mem.o_mem_rd_en = 1'b1;
        mem.o_mem_addr  = rd_addr;
        if (cnt_last) state_d = ST_FLUSH;
      end
      ST_FLUSH: begin
        o_busy  = 1'b1;
        o_TIP   = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Word counter: cleared while idle/computing, stops at the last word.
  always_ff @(posedge i_fft_base_clock) begin
    if (i_fft_reset) begin
      cnt_q <= '0;
    end else if (state_q == ST_IDLE || state_q == ST_COMPUTE) begin
      cnt_q <= '0;
    end else if ((state_q == ST_LOAD || state_q == ST_DRAIN) && !cnt_last) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Core kick pulse and one-cycle-delayed drive tracking of memory reads.
  always_ff @(posedge i_fft_base_clock) begin
    if (i_fft_reset) begin
      go_q      <= 1'b0;
      drv_en_q  <= 1'b0;
      drv_idx_q <= '0;
    end else begin
      go_q      <= (state_q == ST_LOAD) && cnt_last;
      drv_en_q  <= (state_q == ST_DRAIN);
      drv_idx_q <= cnt_q;
    end
  end

  assign o_core_go = go_q;

  assign io_fft_data     = drv_en_q ? mem.i_mem_rd_data : {DATA_WIDTH{1'bz}};
  assign mem.o_out_valid = drv_en_q;
  assign mem.o_out_data  = drv_en_q ? OUT_WIDTH'($signed(mem.i_mem_rd_data)) : '0;
  assign mem.o_out_idx   = drv_en_q ? drv_idx_q : '0;

endmodule

// File: tb/tb_fft2d_stream_port.sv
// Bench for fft2d_stream_port at LOG2N=2 (32-word frames).
module tb_fft2d_stream_port;

  localparam int LOG2N = 2;
  localparam int N     = 4;
  localparam int NW    = 2 * N * N;
  localparam int AW    = 2 * LOG2N + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic i_fft_reset, i_fft_start, i_core_done;
  logic o_TIP, o_busy, o_core_go;
  logic tb_oe;
  logic [15:0] tb_val;
  wire  [15:0] fft_bus;
  assign fft_bus = tb_oe ? tb_val : 16'hzzzz;

  fft2d_stream_port_if #(.DATA_WIDTH(16), .LOG2N(LOG2N), .OUT_WIDTH(32)) mif ();

  fft2d_stream_port #(.DATA_WIDTH(16), .LOG2N(LOG2N), .OUT_WIDTH(32)) dut (
    .i_fft_base_clock (clk),
    .i_fft_reset      (i_fft_reset),
    .io_fft_data      (fft_bus),
    .i_fft_start      (i_fft_start),
    .o_TIP            (o_TIP),
    .o_busy           (o_busy),
    .o_core_go        (o_core_go),
    .i_core_done      (i_core_done),
    .mem              (mif.master)
  );

  // Frame memory model: synchronous write, one-cycle read latency.
  logic [15:0] mem_model [NW];
  always @(posedge clk) begin
    if (mif.o_mem_wr_en) mem_model[mif.o_mem_addr] <= mif.o_mem_wr_data;
    if (mif.o_mem_rd_en) mif.i_mem_rd_data <= mem_model[mif.o_mem_addr];
  end

  int n_err = 0;
  int n_chk = 0;
  logic [15:0] frame [NW];        // what the bench loaded
  logic [31:0] cap_by_addr [NW];  // drained monitor word, keyed by memory address

  typedef struct {
    logic [15:0] din;
    logic [31:0] dout;
  } vec_t;
  vec_t tbl [6];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

`ifdef FFT2D_BITREV_EN
  function automatic int rev(input int x);
    int r = 0;
    for (int b = 0; b < LOG2N; b++) r = r * 2 + ((x >> b) & 1);
    return r;
  endfunction
`endif

  // Memory address read for the k-th drained word.
  function automatic int perm(input int k);
`ifdef FFT2D_BITREV_EN
    return (rev(k / (2 * N)) * N + rev((k / 2) % N)) * 2 + k % 2;
`else
    return k;
`endif
  endfunction

  // Two's-complement value of a 16-bit word, as a 32-bit pattern.
  function automatic logic [31:0] sext(input logic [15:0] w);
    int v;
    v = int'(w);
    if (v >= 32768) v = v - 65536;
    return 32'(v);
  endfunction

  task automatic probe_z(input string nm);
    tb_oe = 1'b1; tb_val = 16'h0000;
    #1;
    check(nm, 32'(fft_bus), 32'h0);
    tb_oe = 1'b0;
  endtask

  // Called at a negedge in IDLE; returns at a negedge in COMPUTE.
  task automatic load_frame(input bit done_noise);
    i_fft_start = 1'b1;
    @(negedge clk);
    i_fft_start = 1'b0;
    tb_oe = 1'b1;
    for (int i = 0; i < NW; i++) begin
      tb_val = frame[i];
      i_core_done = done_noise && (i == 5);
      #1;
      check("load_ctl", {28'h0, mif.o_mem_wr_en, o_busy, o_TIP, mif.o_mem_rd_en}, 32'hE);
      check("load_addr", 32'(mif.o_mem_addr), 32'(i));
      check("load_data", 32'(mif.o_mem_wr_data), 32'(frame[i]));
      @(negedge clk);
    end
    tb_oe = 1'b0;
    i_core_done = 1'b0;
    #1;
    check("go_pulse", {29'h0, o_core_go, o_busy, mif.o_mem_wr_en}, 32'h6);
    @(negedge clk);
    check("go_once", {30'h0, o_core_go, o_busy}, 32'h1);
  endtask

  // Called at a negedge in COMPUTE; returns at a negedge in IDLE.
  task automatic drain_frame(input bit start_in_flush);
    int nrd = 0, nval = 0, cyc = 0;
    bit prev_rd = 1'b0, finished = 1'b0;
    i_core_done = 1'b1;
    @(negedge clk);
    i_core_done = 1'b0;
    while (!finished && cyc < 200) begin
      if (mif.o_mem_rd_en) begin
        check("rd_addr", 32'(mif.o_mem_addr), 32'(perm(nrd)));
        nrd++;
      end
      check("valid_lag", 32'(mif.o_out_valid), 32'(prev_rd));
      if (mif.o_out_valid) begin
        int a;
        a = perm(nval);
        check("out_idx", 32'(mif.o_out_idx), 32'(nval));
        check("out_data", mif.o_out_data, sext(frame[a]));
        check("bus_data", 32'(fft_bus), 32'(frame[a]));
        check("drain_tip", 32'(o_TIP), 32'h1);
        cap_by_addr[a] = mif.o_out_data;
        if (!mif.o_mem_rd_en && start_in_flush) i_fft_start = 1'b1;
        nval++;
      end else if (nval > 0) begin
        finished = 1'b1;
      end
      prev_rd = mif.o_mem_rd_en;
      if (!finished) begin
        @(negedge clk);
        cyc++;
      end
    end
    check("drain_done", 32'(finished), 32'h1);
    check("drain_reads", 32'(nrd), 32'(NW));
    check("drain_words", 32'(nval), 32'(NW));
    i_fft_start = 1'b0;
    check("idle_after", {30'h0, o_busy, o_TIP}, 32'h0);
    @(negedge clk);
    check("flush_start_ignored", 32'(o_busy), 32'h0);
    probe_z("bus_z_after_flush");
  endtask

  initial begin
    i_fft_reset = 1'b1; i_fft_start = 1'b1; i_core_done = 1'b0;
    tb_oe = 1'b0; tb_val = '0;

    // Reset held 3 cycles, with a competing start request.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_status", {28'h0, o_busy, o_TIP, o_core_go, mif.o_out_valid}, 32'h0);
    check("rst_mem", {30'h0, mif.o_mem_wr_en, mif.o_mem_rd_en}, 32'h0);
    check("rst_out", mif.o_out_data | 32'(mif.o_out_idx), 32'h0);
    probe_z("rst_bus_z");
    i_fft_reset = 1'b0; i_fft_start = 1'b0;
    @(negedge clk);

    // core_done while idle does nothing.
    i_core_done = 1'b1;
    @(negedge clk);
    i_core_done = 1'b0;
    check("done_in_idle", 32'(o_busy), 32'h0);
    @(negedge clk);

    // Frame A: words 0..31, done noise during LOAD, start during COMPUTE.
    for (int i = 0; i < NW; i++) frame[i] = 16'(i);
    load_frame(1'b1);
    i_fft_start = 1'b1;
    @(negedge clk);
    i_fft_start = 1'b0;
    check("compute_hold", {28'h0, o_busy, o_TIP, mif.o_mem_wr_en, o_core_go}, 32'h8);
    @(negedge clk);
    check("compute_hold2", {28'h0, o_busy, o_TIP, mif.o_mem_wr_en, o_core_go}, 32'h8);
    drain_frame(1'b1);

    // Frame B: sign-extension table at addresses 0..5.
    tbl[0] = '{16'h8001, 32'hFFFF8001};
    tbl[1] = '{16'h7FFF, 32'h00007FFF};
    tbl[2] = '{16'h0000, 32'h00000000};
    tbl[3] = '{16'hFFFF, 32'hFFFFFFFF};
    tbl[4] = '{16'h8000, 32'hFFFF8000};
    tbl[5] = '{16'h1234, 32'h00001234};
    for (int i = 0; i < NW; i++) frame[i] = (i < 6) ? tbl[i].din : 16'($urandom);
    load_frame(1'b0);
    drain_frame(1'b0);
    for (int i = 0; i < 6; i++) check("sext_tbl", cap_by_addr[i], tbl[i].dout);

    // Random frames with random compute latency.
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < NW; i++) frame[i] = 16'($urandom);
      load_frame(1'b0);
      repeat ($urandom_range(0, 4)) @(negedge clk);
      drain_frame(1'b0);
    end

    // Reset in the middle of DRAIN.
    for (int i = 0; i < NW; i++) frame[i] = 16'($urandom) | 16'h0001;
    load_frame(1'b0);
    i_core_done = 1'b1;
    @(negedge clk);
    i_core_done = 1'b0;
    repeat (10) @(negedge clk);
    check("mid_drain_rd", 32'(mif.o_mem_rd_en), 32'h1);
    i_fft_reset = 1'b1;
    @(negedge clk);
    i_fft_reset = 1'b0;
    check("mid_rst_status", {28'h0, o_busy, o_TIP, mif.o_mem_rd_en, mif.o_out_valid}, 32'h0);
    probe_z("mid_rst_bus_z");
    @(negedge clk);

    // Fresh frame after the abort loads and drains completely.
    for (int i = 0; i < NW; i++) frame[i] = 16'($urandom);
    load_frame(1'b0);
    drain_frame(1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/fft2d_stream_port.md
FFT2D_STREAM_PORT -- requirements
Module: fft2d_stream_port

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- DATA_WIDTH, 16, bus word width.
- LOG2N, 6, log2 of transform side N (N*N complex points, 2*N*N words).
- OUT_WIDTH, 32, width of sign-extended monitor output (>= DATA_WIDTH).
REQ-002 Ports (name, direction, width, meaning), one per line:
- i_fft_base_clock, in, 1, sole clock.
- i_fft_reset, in, 1, synchronous active-high reset.
- io_fft_data, inout, DATA_WIDTH, shared load/drain bus.
- i_fft_start, in, 1, frame start request.
- o_TIP, out, 1, transfer in progress (LOAD or DRAIN).
- o_busy, out, 1, frame in progress.
- o_core_go, out, 1, one-cycle pulse to FFT core.
- i_core_done, in, 1, FFT core finished.
- o_mem_wr_en, out, 1, frame-memory write strobe.
- o_mem_rd_en, out, 1, frame-memory read strobe.
- o_mem_addr, out, 2*LOG2N+1, address {row, col, im}.
- o_mem_wr_data, out, DATA_WIDTH, write data.
- i_mem_rd_data, in, DATA_WIDTH, read data, valid 1 cycle after o_mem_rd_en.
- o_out_valid, out, 1, monitor word valid.
- o_out_data, out, OUT_WIDTH, sign-extended drained word.
- o_out_idx, out, 2*LOG2N+1, sequence index of drained word.

Function
REQ-003 FSM states IDLE, LOAD, COMPUTE, DRAIN, FLUSH; every transition on rising i_fft_base_clock.
REQ-004 IDLE: i_fft_start=1 -> LOAD next cycle; word counter cleared.
REQ-005 LOAD: each cycle sample io_fft_data; o_mem_wr_en=1, o_mem_addr=counter, o_mem_wr_data=sample; counter +1.
REQ-006 LOAD ends after 2*N*N writes; following cycle o_core_go=1 for exactly one cycle, state COMPUTE.
REQ-007 COMPUTE: i_core_done=1 -> DRAIN, counter cleared; i_core_done outside COMPUTE ignored.
REQ-008 DRAIN: o_mem_rd_en=1 for 2*N*N consecutive cycles; io_fft_data driven with i_mem_rd_data one cycle after each read; then FLUSH for the final driven word, then IDLE.
REQ-009 io_fft_data high-Z in all states/cycles except those driving drained data.
REQ-010 o_out_valid high exactly in cycles io_fft_data is driven; o_out_data = sign-extension of driven word to OUT_WIDTH; o_out_idx = 0,1,2... per frame.
REQ-011 o_busy=1 in LOAD, COMPUTE, DRAIN, FLUSH; o_TIP=1 in LOAD, DRAIN, FLUSH.
REQ-012 i_fft_start ignored when not in IDLE; start in same cycle FLUSH->IDLE is ignored (start seen only while state is IDLE).
REQ-013 Counter width 2*LOG2N+1; terminal compare at 2*N*N-1, no wrap beyond.

Reset
REQ-014 i_fft_reset=1 at clock edge: state IDLE, counters 0, all outputs 0, bus high-Z from next cycle, including mid-LOAD/DRAIN.
REQ-015 Reset has priority over every other input in the same cycle.

Configuration
REQ-016 Macro FFT2D_BITREV_EN defined: DRAIN read address = {bitrev(row), bitrev(col), im} over LOG2N bits each, row/col/im taken from the sequence counter; load order unaffected.
REQ-017 FFT2D_BITREV_EN undefined: DRAIN read address = sequence counter (natural order); no bit-reverse logic synthesised.

Structure
REQ-018 Shared package fft2d_pkg: state enum, default DATA_WIDTH/LOG2N/OUT_WIDTH constants, address-width function.
REQ-019 One sub-module fft2d_bitrev (LOG2N-parameterised combinational reverser), instantiated only under FFT2D_BITREV_EN.

Verification (LOG2N=2, N=4, 32 words, DATA_WIDTH=16)
REQ-020 Reset held 3 cycles -> o_busy=o_TIP=o_core_go=o_out_valid=0, io_fft_data=Z.
REQ-021 Start, drive words 0..31 -> writes addr 0..31 data 0..31, o_core_go one cycle after last write, o_busy=1.
REQ-022 i_core_done, memory holds addr value, macro off -> drained words 0..31 in order, o_out_idx 0..31, bus Z after FLUSH.
REQ-023 Macro on, same memory -> drained order 0,1,4,5,2,3,6,7,16,17,20,21,...
REQ-024 Memory word 16'h8001 drained -> o_out_data=32'hFFFF8001; 16'h7FFF -> 32'h00007FFF.
REQ-025 Start pulse during COMPUTE ignored; reset asserted mid-DRAIN -> IDLE, bus Z next cycle; new start then loads full 32 words.
